vx_tcache_rsp_arb: RTL and testbench



---
 rtl/vx_tcache_rsp_arb.sv | 183 ++++++++++++++++++
 tb/tb_vx_tcache_rsp_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_tcache_rsp_arb.sv
`default_nettype none
// ============================================================================
// Module      : vx_tcache_rsp_arb
// Description : Merges texture-cache responses from NUM_INPUTS sources into a
//               single response stream. A round-robin arbiter chooses one valid
//               source per cycle. The winner's response goes into a 2-entry
//               output FIFO. The source index is appended in the low bits of
//               the outgoing tag so the consumer can route the response back.
//
// Ports       : clk        - single clock; all state updates on rising edge
//               reset      - synchronous, active-high
//               in_valid   - [NUM_INPUTS]               per-source valid
//               in_tmask   - [NUM_INPUTS*NUM_REQS]      per-source lane mask
//               in_data    - [NUM_INPUTS*NUM_REQS*WW]   per-source lane data
//               in_tag     - [NUM_INPUTS*TAG_WIDTH]     per-source tag
//               in_ready   - [NUM_INPUTS]               per-source accept
//               rsp_valid  - merged response valid
//               rsp_tmask  - [NUM_REQS]                 merged lane mask
//               rsp_data   - [NUM_REQS*WW]              merged lane data
//               rsp_tag    - [TAG_WIDTH+LOG_IN]         {source tag, source idx}
//               rsp_ready  - downstream accept
//               stall_cnt  - [32] cycles with rsp_valid=1 and rsp_ready=0
//
// Revision    : 1.0 - initial release
// ============================================================================
module vx_tcache_rsp_arb #(
    parameter int NUM_INPUTS = 4,
    parameter int NUM_REQS   = 4,
    parameter int WORD_SIZE  = 4,
    parameter int TAG_WIDTH  = 8,
    localparam int LOG_IN    = $clog2(NUM_INPUTS),
    localparam int WW        = 8 * WORD_SIZE
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic [NUM_INPUTS-1:0]                in_valid,
    input  logic [NUM_INPUTS*NUM_REQS-1:0]       in_tmask,
    input  logic [NUM_INPUTS*NUM_REQS*WW-1:0]    in_data,
    input  logic [NUM_INPUTS*TAG_WIDTH-1:0]      in_tag,
    output logic [NUM_INPUTS-1:0]                in_ready,

    output logic                                 rsp_valid,
    output logic [NUM_REQS-1:0]                  rsp_tmask,
    output logic [NUM_REQS*WW-1:0]               rsp_data,
    output logic [TAG_WIDTH+LOG_IN-1:0]          rsp_tag,
    input  logic                                 rsp_ready,

    output logic [31:0]                          stall_cnt
);

    localparam int c_src_data_w = NUM_REQS * WW;
    localparam int c_out_tag_w  = TAG_WIDTH + LOG_IN;

    // ------------------------------------------------------------------------
    // Per-source views of the flattened input buses
    // ------------------------------------------------------------------------
    logic [NUM_REQS-1:0]     w_src_tmask [NUM_INPUTS];
    logic [c_src_data_w-1:0] w_src_data  [NUM_INPUTS];
    logic [TAG_WIDTH-1:0]    w_src_tag   [NUM_INPUTS];

    generate
        for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_src
            assign w_src_tmask[i] = in_tmask[i*NUM_REQS +: NUM_REQS];
            assign w_src_data[i]  = in_data[i*c_src_data_w +: c_src_data_w];
            assign w_src_tag[i]   = in_tag[i*TAG_WIDTH +: TAG_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [LOG_IN-1:0]       r_last_grant;
    logic [1:0]              r_count;
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [31:0]             r_stall_cnt;

    // Two-entry payload storage; the head entry drives the outputs directly.
    logic [NUM_REQS-1:0]     r_mem_tmask [2];
    logic [c_src_data_w-1:0] r_mem_data  [2];
    logic [c_out_tag_w-1:0]  r_mem_tag   [2];

    // ------------------------------------------------------------------------
    // Round-robin arbiter
    // The search starts one past the last accepted source and wraps. Only the
    // first valid candidate found is kept.
    // ------------------------------------------------------------------------
    logic                    w_any_valid;
    logic                    w_found;
    logic [LOG_IN-1:0]       w_cand;
    logic [LOG_IN-1:0]       w_grant;

    always_comb begin
        w_found = 1'b0;
        w_cand  = '0;
        w_grant = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            w_cand = LOG_IN'((int'(r_last_grant) + k) % NUM_INPUTS);
            if (!w_found && in_valid[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    assign w_any_valid = |in_valid;

    // ------------------------------------------------------------------------
    // Handshake decode
    // Fullness comes only from the registered count. As a result, in_ready
    // has no combinational path from rsp_ready. A pop in a full cycle frees
    // a slot one cycle later.
    // ------------------------------------------------------------------------
    logic                    w_full;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_rsp_valid;

    assign w_full      = (r_count == 2'd2);
    assign w_push      = !reset && w_any_valid && !w_full;
    assign w_rsp_valid = !reset && (r_count != 2'd0);
    assign w_pop       = w_rsp_valid && rsp_ready;

    generate
        for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ready
            assign in_ready[i] = w_push && (w_grant == LOG_IN'(i));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count      <= 2'd0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            // Start just before source 0 so that source 0 wins first.
            r_last_grant <= LOG_IN'(NUM_INPUTS - 1);
            r_stall_cnt  <= 32'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr     <= ~r_wr_ptr;
                r_last_grant <= w_grant;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            // Free-running wrap at 2^32-1 is intended.
            if (w_rsp_valid && !rsp_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Payload storage (not reset; validity is tracked by r_count)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_tmask[r_wr_ptr] <= w_src_tmask[w_grant];
            r_mem_data[r_wr_ptr]  <= w_src_data[w_grant];
            r_mem_tag[r_wr_ptr]   <= {w_src_tag[w_grant], w_grant};
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rsp_valid = w_rsp_valid;
    assign rsp_tmask = r_mem_tmask[r_rd_ptr];
    assign rsp_data  = r_mem_data[r_rd_ptr];
    assign rsp_tag   = r_mem_tag[r_rd_ptr];
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vx_tcache_rsp_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_tcache_rsp_arb
// Description : Self-checking bench for vx_tcache_rsp_arb. It uses a vector
//               table for arbitration order, hand sequences for the full,
//               stall and reset cases, and a randomized run. All three feed a
//               negedge scoreboard with its own round-robin / FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_tcache_rsp_arb;

    localparam int NI  = 4;
    localparam int NR  = 4;
    localparam int WS  = 4;
    localparam int TW  = 8;
    localparam int LI  = 2;
    localparam int WW  = 8 * WS;
    localparam int SDW = NR * WW;

    logic               clk = 1'b0;
    logic               reset;
    logic [NI-1:0]      in_valid;
    logic [NI*NR-1:0]   in_tmask;
    logic [NI*SDW-1:0]  in_data;
    logic [NI*TW-1:0]   in_tag;
    logic [NI-1:0]      in_ready;
    logic               rsp_valid;
    logic [NR-1:0]      rsp_tmask;
    logic [SDW-1:0]     rsp_data;
    logic [TW+LI-1:0]   rsp_tag;
    logic               rsp_ready;
    logic [31:0]        stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vx_tcache_rsp_arb #(
        .NUM_INPUTS (NI),
        .NUM_REQS   (NR),
        .WORD_SIZE  (WS),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_tmask   (in_tmask),
        .in_data    (in_data),
        .in_tag     (in_tag),
        .in_ready   (in_ready),
        .rsp_valid  (rsp_valid),
        .rsp_tmask  (rsp_tmask),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_ready  (rsp_ready),
        .stall_cnt  (stall_cnt)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [NI-1:0] v, input logic [NR-1:0] tm,
                         input logic [WW-1:0] w, input logic [TW-1:0] t);
        in_valid = v;
        for (int i = 0; i < NI; i++) begin
            in_tmask[i*NR +: NR]  = tm;
            in_data[i*SDW +: SDW] = {NR{w}};
            in_tag[i*TW +: TW]    = t;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = '0;
        tick();
        tick();
        reset    = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Scoreboard: reference model of the arbiter and the 2-entry output queue.
    // It evaluates each cycle on the falling edge, while the inputs are stable.
    // ------------------------------------------------------------------------
    typedef struct {
        logic [NR-1:0]    tmask;
        logic [SDW-1:0]   data;
        logic [TW+LI-1:0] tag;
    } rsp_t;

    rsp_t        sb_q[$];
    int          m_count = 0;
    logic [LI-1:0] m_last = LI'(NI - 1);
    logic [31:0] m_stall = 32'd0;

    always @(negedge clk) begin : p_mon
        logic [NI-1:0] exp_rdy;
        logic          found;
        logic          pop;
        int            wi;
        int            c;
        rsp_t          e;
        if (reset) begin
            check("rst_in_ready", in_ready, '0);
            check("rst_rsp_valid", rsp_valid, 1'b0);
            sb_q.delete();
            m_count = 0;
            m_last  = LI'(NI - 1);
            m_stall = 32'd0;
        end else begin
            exp_rdy = '0;
            found   = 1'b0;
            wi      = 0;
            for (int k = 1; k <= NI; k++) begin
                c = (int'(m_last) + k) % NI;
                if (!found && in_valid[c]) begin
                    found = 1'b1;
                    wi    = c;
                end
            end
            if (found && m_count < 2) exp_rdy[wi] = 1'b1;
            check("sb_in_ready", in_ready, exp_rdy);
            check("sb_rsp_valid", rsp_valid, m_count != 0);
            check("sb_stall_cnt", stall_cnt, m_stall);
            pop = (m_count != 0) && rsp_ready;
            if (pop) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got output expected none");
                end else begin
                    e = sb_q.pop_front();
                    check("sb_tmask", rsp_tmask, e.tmask);
                    check("sb_data", rsp_data, e.data);
                    check("sb_tag", rsp_tag, e.tag);
                end
            end
            if (m_count != 0 && !rsp_ready) m_stall = m_stall + 32'd1;
            if (exp_rdy != '0) begin
                e.tmask = in_tmask[wi*NR +: NR];
                e.data  = in_data[wi*SDW +: SDW];
                e.tag   = {in_tag[wi*TW +: TW], LI'(wi)};
                sb_q.push_back(e);
                m_last = LI'(wi);
            end
            m_count = m_count + ((exp_rdy != '0) ? 1 : 0) - (pop ? 1 : 0);
        end
    end

    // ------------------------------------------------------------------------
    // Vector table: arbitration order from reset with rsp_ready held high
    // ------------------------------------------------------------------------
    typedef struct {
        logic [NI-1:0]    valid;
        logic [NR-1:0]    tmask;
        logic [WW-1:0]    word;
        logic [TW-1:0]    tag;
        logic [NI-1:0]    exp_ready;
        logic [TW+LI-1:0] exp_otag;
    } vec_t;

    vec_t vt[12];

    initial begin : p_watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : p_main
        logic [NI-1:0] acc;

        vt[0]  = '{4'b1111, 4'hF, 32'h11111111, 8'h10, 4'b0001, 10'h040};
        vt[1]  = '{4'b1111, 4'hF, 32'h22222222, 8'h20, 4'b0010, 10'h081};
        vt[2]  = '{4'b1111, 4'h3, 32'h33333333, 8'h30, 4'b0100, 10'h0C2};
        vt[3]  = '{4'b1111, 4'hC, 32'h44444444, 8'h40, 4'b1000, 10'h103};
        vt[4]  = '{4'b1111, 4'h0, 32'h55555555, 8'h50, 4'b0001, 10'h140};
        vt[5]  = '{4'b0000, 4'hF, 32'h00000000, 8'h00, 4'b0000, 10'h000};
        vt[6]  = '{4'b1010, 4'h5, 32'h66666666, 8'h60, 4'b0010, 10'h181};
        vt[7]  = '{4'b1010, 4'h6, 32'h77777777, 8'h70, 4'b1000, 10'h1C3};
        vt[8]  = '{4'b0100, 4'hA, 32'hDEADBEEF, 8'h5A, 4'b0100, 10'h16A};
        vt[9]  = '{4'b0011, 4'h9, 32'h99999999, 8'h90, 4'b0001, 10'h240};
        vt[10] = '{4'b0011, 4'h1, 32'hAAAAAAAA, 8'hA0, 4'b0010, 10'h281};
        vt[11] = '{4'b1001, 4'h8, 32'hBBBBBBBB, 8'hB0, 4'b1000, 10'h2C3};

        reset     = 1'b1;
        in_valid  = '0;
        in_tmask  = '0;
        in_data   = '0;
        in_tag    = '0;
        rsp_ready = 1'b1;
        acc       = '0;
        do_reset();
        check("reset_stall_cnt", stall_cnt, 32'd0);
        check("reset_rsp_valid", rsp_valid, 1'b0);

        // Table run: one accept per cycle, each visible on the next cycle.
        for (int v = 0; v < 12; v++) begin
            apply(vt[v].valid, vt[v].tmask, vt[v].word, vt[v].tag);
            #1;
            check("tbl_in_ready", in_ready, vt[v].exp_ready);
            tick();
            check("tbl_rsp_valid", rsp_valid, vt[v].exp_ready != '0);
            if (vt[v].exp_ready != '0) begin
                check("tbl_rsp_tag", rsp_tag, vt[v].exp_otag);
                check("tbl_rsp_tmask", rsp_tmask, vt[v].tmask);
                check("tbl_rsp_data", rsp_data, {NR{vt[v].word}});
            end
        end
        in_valid = '0;
        repeat (3) tick();

        // Backpressure: fill the FIFO, stall, then release.
        do_reset();
        apply(4'b1010, 4'hF, 32'hC0DE0001, 8'h31);
        rsp_ready = 1'b0;
        #1;
        check("bp_grant1", in_ready, 4'b0010);
        tick();
        in_valid = 4'b1000;
        #1;
        check("bp_grant3", in_ready, 4'b1000);
        tick();
        in_valid = 4'b0001;
        #1;
        check("bp_full_ready", in_ready, 4'b0000);
        check("bp_full_valid", rsp_valid, 1'b1);
        check("bp_stall1", stall_cnt, 32'd1);
        repeat (3) tick();
        check("bp_stall4", stall_cnt, 32'd4);
        rsp_ready = 1'b1;
        #1;
        check("bp_pop_ready", in_ready, 4'b0000);
        check("bp_first_out", rsp_tag[LI-1:0], 2'd1);
        tick();
        check("bp_reassert", in_ready, 4'b0001);
        check("bp_second_out", rsp_tag[LI-1:0], 2'd3);
        tick();
        in_valid = '0;
        repeat (3) tick();

        // Reset while the FIFO is full, then check that source 0 wins first.
        do_reset();
        apply(4'b1001, 4'hF, 32'hCAFE0000, 8'h77);
        rsp_ready = 1'b0;
        #1;
        check("rs_grant0", in_ready, 4'b0001);
        tick();
        in_valid = 4'b1000;
        tick();
        in_valid = 4'b1001;
        reset    = 1'b1;
        tick();
        check("rs_rsp_valid", rsp_valid, 1'b0);
        check("rs_in_ready", in_ready, 4'b0000);
        check("rs_stall_cnt", stall_cnt, 32'd0);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("rs_first_grant", in_ready, 4'b0001);
        tick();
        in_valid = '0;
        repeat (3) tick();

        // Randomized valid/ready traffic; the scoreboard checks every transfer.
        do_reset();
        acc = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < NI; i++) begin
                if (!in_valid[i] || acc[i]) begin
                    in_valid[i]           = ($urandom_range(0, 99) < 60);
                    in_tmask[i*NR +: NR]  = NR'($urandom);
                    in_data[i*SDW +: SDW] = {$urandom, $urandom, $urandom, $urandom};
                    in_tag[i*TW +: TW]    = TW'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 99) < 70);
            @(negedge clk);
            acc = in_valid & in_ready;
            tick();
        end
        in_valid  = '0;
        rsp_ready = 1'b1;
        repeat (4) tick();
        check("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
